// File: rtl/uart_tx_fifo.sv
// UART transmitter with a host-side byte FIFO and CTS flow control.
// Each frame on Tx is: start bit, data MSB first, optional even parity, then stop bits.
module uart_tx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_BIT = 1,
    parameter int unsigned STOP_BITS  = 2,
    parameter int unsigned FIFO_WIDTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [DATA_BITS-1:0]  Tx_Data,
    input  logic                  Push_Data,
    input  logic                  CTS,
    output logic                  Tx,
    output logic                  Tx_Busy,
    output logic                  FIFO_Empty,
    output logic                  FIFO_Full,
    output logic [FIFO_WIDTH:0]   FIFO_Count,
    output logic                  Tx_Overflow
);

    localparam int unsigned Depth  = 2 ** FIFO_WIDTH;
    localparam int unsigned CntMax = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [DATA_BITS-1:0]  mem_q [Depth];
    logic [FIFO_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_WIDTH:0]   count_q, count_d;
    logic                  overflow_q;
    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  pop, push_ok, empty, full;
    logic [DATA_BITS-1:0]  head;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (FIFO_WIDTH + 1)'(Depth));
    assign head    = mem_q[rd_ptr_q];
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign push_ok = Push_Data && (!full || pop);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!empty && CTS) begin
                    pop      = 1'b1;
                    state_d  = StStart;
                    tx_d     = 1'b0;
                    shift_d  = head;
                    parity_d = ^head;
                end
            end
            StStart: begin
                state_d = StData;
                tx_d    = shift_q[DATA_BITS-1];
                shift_d = shift_q << 1;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntW'(DATA_BITS - 1)) begin
                    cnt_d = '0;
                    if (PARITY_BIT != 0) begin
                        state_d = StParity;
                        tx_d    = parity_q;
                    end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    tx_d    = shift_q[DATA_BITS-1];
                    shift_d = shift_q << 1;
                end
            end
            StParity: begin
                state_d = StStop;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
            StStop: begin
                if (cnt_q == CntW'(STOP_BITS - 1)) begin
                    cnt_d = '0;
                    // Back-to-back frames: the next start bit follows the last stop bit directly.
                    if (!empty && CTS) begin
                        pop      = 1'b1;
                        state_d  = StStart;
                        tx_d     = 1'b0;
                        shift_d  = head;
                        parity_d = ^head;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    tx_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            count_q  <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (Push_Data && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= Tx_Data;
        end
    end

    assign Tx          = tx_q;
    assign Tx_Busy     = (state_q != StIdle);
    assign FIFO_Empty  = empty;
    assign FIFO_Full   = full;
    assign FIFO_Count  = count_q;
    assign Tx_Overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: vector table, directed corner sequences and random traffic,
// all checked against a queue-based model of the FIFO and the serial line.
module tb_uart_tx_fifo;

    localparam int Depth = 16;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic [7:0] Tx_Data = '0;
    logic       Push_Data = 1'b0;
    logic       CTS = 1'b0;
    logic       Tx, Tx_Busy, FIFO_Empty, FIFO_Full, Tx_Overflow;
    logic [4:0] FIFO_Count;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Tx_Data    (Tx_Data),
        .Push_Data  (Push_Data),
        .CTS        (CTS),
        .Tx         (Tx),
        .Tx_Busy    (Tx_Busy),
        .FIFO_Empty (FIFO_Empty),
        .FIFO_Full  (FIFO_Full),
        .FIFO_Count (FIFO_Count),
        .Tx_Overflow(Tx_Overflow)
    );

    always #5 Clk = ~Clk;

    // Model: queued bytes, bits still to send in the current frame, and line outputs.
    logic [7:0] q_m [$];
    bit         bits_m [$];
    logic       tx_m = 1'b1;
    logic       busy_m = 1'b0;
    logic       ovf_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {22'd0, Tx, Tx_Busy, FIFO_Empty, FIFO_Full, Tx_Overflow, FIFO_Count};
    endfunction

    function automatic logic [31:0] mk_vec(logic t, logic b, logic e, logic f, logic o, int c);
        return {22'd0, t, b, e, f, o, 5'(c)};
    endfunction

    task automatic model_reset();
        q_m.delete();
        bits_m.delete();
        tx_m   = 1'b1;
        busy_m = 1'b0;
        ovf_m  = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic [7:0] d, input logic c);
        logic       pop_now, accept;
        logic [7:0] b;
        pop_now = (bits_m.size() == 0) && (q_m.size() > 0) && c;
        accept  = p && ((q_m.size() < Depth) || pop_now);
        if (p && !accept) ovf_m = 1'b1;
        if (pop_now) begin
            b = q_m.pop_front();
            bits_m.push_back(1'b0);
            for (int i = 7; i >= 0; i--) bits_m.push_back(b[i]);
            bits_m.push_back(^b);
            bits_m.push_back(1'b1);
            bits_m.push_back(1'b1);
        end
        if (bits_m.size() > 0) begin
            tx_m   = bits_m.pop_front();
            busy_m = 1'b1;
        end else begin
            tx_m   = 1'b1;
            busy_m = 1'b0;
        end
        if (accept) q_m.push_back(d);
    endtask

    task automatic step(input logic p, input logic [7:0] d, input logic c);
        Push_Data = p;
        Tx_Data   = p ? d : 8'($urandom);
        CTS       = c;
        @(posedge Clk);
        model_step(p, Tx_Data, c);
        #1;
        chk("model", dut_vec(), mk_vec(tx_m, busy_m, q_m.size() == 0, q_m.size() == Depth,
                                       ovf_m, q_m.size()));
    endtask

    task automatic do_reset();
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_reset", dut_vec(), mk_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0));
        model_reset();
        Push_Data = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    typedef struct {
        logic       push;
        logic [7:0] data;
        logic       cts;
        logic       exp_tx;
        logic       exp_busy;
        logic [4:0] exp_cnt;
    } vec_t;

    vec_t       tbl [14];
    logic [11:0] a5_frame;
    logic [35:0] exp3, cap3;
    logic       cts_r;

    initial begin
        a5_frame = 12'b010100101011;
        tbl[0] = '{push: 1'b1, data: 8'hA5, cts: 1'b1, exp_tx: 1'b1, exp_busy: 1'b0,
                   exp_cnt: 5'd1};
        for (int i = 0; i < 12; i++)
            tbl[i + 1] = '{push: 1'b0, data: 8'h00, cts: 1'b1, exp_tx: a5_frame[11 - i],
                           exp_busy: 1'b1, exp_cnt: 5'd0};
        tbl[13] = '{push: 1'b0, data: 8'h00, cts: 1'b1, exp_tx: 1'b1, exp_busy: 1'b0,
                    exp_cnt: 5'd0};

        do_reset();

        // Single 0xA5 frame from the vector table.
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].push, tbl[i].data, tbl[i].cts);
            chk($sformatf("vec%0d", i), {Tx, Tx_Busy, FIFO_Count},
                {tbl[i].exp_tx, tbl[i].exp_busy, tbl[i].exp_cnt});
        end

        // Three back-to-back frames, no idle gap between them.
        exp3 = {12'b000000001111, 12'b000000010111, 12'b000000011011};
        cap3 = '0;
        step(1'b1, 8'h01, 1'b1);
        step(1'b1, 8'h02, 1'b1);
        cap3 = {cap3[34:0], Tx};
        step(1'b1, 8'h03, 1'b1);
        cap3 = {cap3[34:0], Tx};
        chk("b2b_count", 32'(FIFO_Count), 32'd2);
        for (int i = 0; i < 34; i++) begin
            step(1'b0, 8'h00, 1'b1);
            cap3 = {cap3[34:0], Tx};
        end
        chk("b2b_bits", 32'(cap3), 32'(exp3));
        chk("b2b_bits_hi", 32'(cap3[35:32]), 32'(exp3[35:32]));
        step(1'b0, 8'h00, 1'b1);
        chk("b2b_idle", {Tx, Tx_Busy, FIFO_Count}, {1'b1, 1'b0, 5'd0});

        // Reset mid-frame.
        step(1'b1, 8'hC3, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b1);
        do_reset();

        // CTS gating and CTS drop mid-frame.
        step(1'b1, 8'h55, 1'b0);
        repeat (5) step(1'b0, 8'h00, 1'b0);
        chk("cts_hold", {Tx, Tx_Busy, FIFO_Count}, {1'b1, 1'b0, 5'd1});
        step(1'b0, 8'h00, 1'b1);
        chk("cts_start", {Tx, Tx_Busy, FIFO_Count}, {1'b0, 1'b1, 5'd0});
        repeat (3) step(1'b0, 8'h00, 1'b1);
        repeat (8) step(1'b0, 8'h00, 1'b0);
        chk("cts_last_stop", {Tx, Tx_Busy}, {1'b1, 1'b1});
        step(1'b0, 8'h00, 1'b0);
        chk("cts_done", {Tx, Tx_Busy}, {1'b1, 1'b0});

        // Overflow: 17 pushes into a 16-deep FIFO with CTS low.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 1'b0);
        chk("ovf_state", {FIFO_Full, Tx_Overflow, FIFO_Count}, {1'b1, 1'b1, 5'd16});
        repeat (16 * 12 + 2) step(1'b0, 8'h00, 1'b1);
        chk("ovf_drained", {FIFO_Empty, Tx_Overflow, FIFO_Count}, {1'b1, 1'b1, 5'd0});

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
        chk("full_state", {FIFO_Full, Tx_Overflow, FIFO_Count}, {1'b1, 1'b0, 5'd16});
        step(1'b1, 8'hEE, 1'b1);
        chk("full_pushpop", {FIFO_Full, Tx_Overflow, FIFO_Count, Tx}, {1'b1, 1'b0, 5'd16, 1'b0});
        repeat (17 * 12 + 2) step(1'b0, 8'h00, 1'b1);
        chk("full_drained", {FIFO_Empty, Tx_Overflow, Tx_Busy}, {1'b1, 1'b0, 1'b0});

        // Random traffic with slowly wandering CTS.
        do_reset();
        cts_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5) cts_r = ~cts_r;
            step($urandom_range(0, 99) < 12, 8'($urandom), cts_r);
        end
        repeat (Depth * 12 + 20) step(1'b0, 8'h00, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
